dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port arbiter and access sequencer in front of the single-port, byte-addressable data memory. It shares the memory between the core load/store unit (port 0) and a debug/DMA master (port 1) using round-robin arbitration and a valid/ready handshake. It rejects misaligned, out-of-range and illegal-size accesses before they reach memory, and returns one tagged response per accepted request.

## Interface
Parameters:
- MEM_BYTES, 2048: memory size in bytes. Valid addresses are 0 .. MEM_BYTES-1.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  2  per-port request valid. Bit 0 = LSU, bit 1 = DMA.
- o_req_ready  out  2  per-port accept. A transfer happens when valid and ready are both high at a rising edge.
- i_req_we  in  2  per-port write enable.
- i_req_addr0, i_req_addr1  in  32  byte address.
- i_req_wd0, i_req_wd1  in  32  write data, LSB-aligned.
- i_req_mask0, i_req_mask1  in  2  access size: 00 byte, 01 halfword, 10 word, 11 illegal.
- i_req_ext  in  2  per-port load extension: 0 sign, 1 zero.
- o_mem_we  out  1  memory write enable.
- o_mem_addr  out  32  memory byte address.
- o_mem_wd  out  32  memory write data.
- o_mem_mask_type  out  2  memory access size.
- o_mem_ext_type  out  1  memory extension type.
- i_mem_rd  in  32  combinational read data from memory.
- o_rsp_valid  out  1  one-cycle response strobe.
- o_rsp_id  out  1  port that issued the request being answered.
- o_rsp_rdata  out  32  load data; 0 for stores and errors.
- o_rsp_err  out  1  request was rejected and memory was not touched.

## Operation
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - o_req_ready is high for exactly the selected port; all other ready bits are 0.
  - Selection: if only one port is valid, select it. If both are valid, select the port that is not last_grant.
  - On the handshake, latch we, addr, wd, mask, ext and id from the selected port, update last_grant, and go to ACCESS.
  - A request that is not accepted must hold valid and all its fields stable until accepted.
- Error check is computed from the latched fields and is combinational:
  - mask = 11, or
  - halfword with addr[0] = 1, or
  - word with addr[1:0] ≠ 0, or
  - addr + size - 1 ≥ MEM_BYTES. This sum is evaluated 33 bits wide so 0xFFFF_FFFF does not wrap.
- ACCESS (one cycle):
  - o_mem_* drive the latched fields.
  - o_mem_we = latched we AND no error, so the store commits at the edge that ends ACCESS.
  - For a load with no error, capture i_mem_rd into the response register at that edge.
  - Go to RESP.
- RESP (one cycle):
  - o_rsp_valid = 1, with o_rsp_id, o_rsp_rdata and o_rsp_err from registers.
  - Go to IDLE.
- o_mem_we is 0 in every state except ACCESS. o_mem_addr, o_mem_wd, o_mem_mask_type and o_mem_ext_type hold their last latched values outside ACCESS.
- Reset values:
  - state IDLE, last_grant = 1 (so port 0 wins the first tie).
  - All latched fields 0.
  - o_mem_we 0, o_mem_addr 0, o_mem_wd 0, o_mem_mask_type 00, o_mem_ext_type 0.
  - o_rsp_valid 0, o_rsp_id 0, o_rsp_rdata 0, o_rsp_err 0.
  - o_req_ready reflects IDLE selection as soon as reset deasserts.

## Timing
- Request accepted at edge T. Memory access occupies cycle T..T+1. o_rsp_valid is high in cycle T+1..T+2. The next acceptance is possible at edge T+2.
- Throughput: one request per 3 cycles. Each port gets at least one grant per 6 cycles under contention.
- o_req_ready is 0 throughout ACCESS and RESP. Requests arriving then wait.
- An erroring request still takes the full 3 cycles and produces a response with o_rsp_err = 1.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and asynchronously, and o_mem_we drops in the same instant. The in-flight request is dropped with no response; a store in ACCESS does not commit.
- The response is always issued; there is no backpressure on the response channel.

## Test plan
- Port 0 store word 0xDEADBEEF at 0x10, then load word at 0x10 -> second response: id 0, rdata 0xDEADBEEF, err 0, o_rsp_valid exactly 2 cycles after each accept.
- Both ports valid continuously from reset, loads at 0x0 and 0x4 -> grants alternate 0,1,0,1; a new accept every 3 cycles; responses tagged with the matching id.
- Port 1 store halfword at 0x3 -> o_rsp_err 1, rdata 0, o_mem_we never asserted; a subsequent byte load at 0x3 returns 0.
- Port 0 load word at MEM_BYTES-2 and at 0xFFFF_FFFC -> both responses err 1. Load byte at MEM_BYTES-1 -> err 0.
- Byte 0x80 stored at 0x20, then byte load with ext 0 -> rdata 0xFFFFFF80; with ext 1 -> rdata 0x00000080.
- Assert i_rst_n low during ACCESS of a word store of 0x12345678 to 0x40 -> no response, o_mem_we 0 immediately. After release, a load of 0x40 returns the old value and port 0 wins the first tie.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port data memory; 3 cycles per request.
// Ready only in IDLE for the selected port, so a waiting port holds its request; responses are never stalled.
module dmem_arbiter #(
   parameter int MEM_BYTES = 2048
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [1:0]  i_req_valid,
   output logic [1:0]  o_req_ready,
   input  logic [1:0]  i_req_we,
   input  logic [31:0] i_req_addr0,
   input  logic [31:0] i_req_addr1,
   input  logic [31:0] i_req_wd0,
   input  logic [31:0] i_req_wd1,
   input  logic [1:0]  i_req_mask0,
   input  logic [1:0]  i_req_mask1,
   input  logic [1:0]  i_req_ext,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wd,
   output logic [1:0]  o_mem_mask_type,
   output logic        o_mem_ext_type,
   input  logic [31:0] i_mem_rd,
   output logic        o_rsp_valid,
   output logic        o_rsp_id,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [1:0]  mask;
      logic        ext;
      logic        id;
   } req_t;

   state_t      r_state, w_state_nxt;
   req_t        r_req, w_req_sel;
   logic        r_last_grant;
   logic        w_sel;
   logic        w_accept;
   logic        w_err;
   logic [32:0] w_size;
   logic [32:0] w_last_byte;
   logic [31:0] r_rsp_rdata;
   logic        r_rsp_err;

   // A lone requester always wins; on a tie the port not granted last time wins.
   always_comb begin
      w_sel = ~r_last_grant;
      if (i_req_valid == 2'b01)
         w_sel = 1'b0;
      else if (i_req_valid == 2'b10)
         w_sel = 1'b1;
   end

   always_comb begin
      w_req_sel.we   = i_req_we[w_sel];
      w_req_sel.addr = w_sel ? i_req_addr1 : i_req_addr0;
      w_req_sel.wd   = w_sel ? i_req_wd1 : i_req_wd0;
      w_req_sel.mask = w_sel ? i_req_mask1 : i_req_mask0;
      w_req_sel.ext  = i_req_ext[w_sel];
      w_req_sel.id   = w_sel;
   end

   always_comb begin
      case (r_req.mask)
         2'b00:   w_size = 33'd1;
         2'b01:   w_size = 33'd2;
         default: w_size = 33'd4;
      endcase
   end

   // 33-bit end address so accesses near 0xFFFF_FFFF cannot wrap into range.
   assign w_last_byte = {1'b0, r_req.addr} + w_size - 33'd1;
   assign w_err = (r_req.mask == 2'b11)
                | ((r_req.mask == 2'b01) && r_req.addr[0])
                | ((r_req.mask == 2'b10) && (r_req.addr[1:0] != 2'b00))
                | (w_last_byte >= 33'(MEM_BYTES));

   always_comb begin
      w_state_nxt = r_state;
      o_req_ready = 2'b00;
      w_accept    = 1'b0;
      o_mem_we    = 1'b0;
      o_rsp_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_req_ready = w_sel ? 2'b10 : 2'b01;
            w_accept    = i_req_valid[w_sel];
            if (w_accept)
               w_state_nxt = S_ACCESS;
         end
         S_ACCESS: begin
            o_mem_we    = r_req.we & ~w_err;
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            o_rsp_valid = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_req        <= '0;
         r_rsp_rdata  <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_req        <= w_req_sel;
            r_last_grant <= w_sel;
         end
         if (r_state == S_ACCESS) begin
            r_rsp_rdata <= (!r_req.we && !w_err) ? i_mem_rd : 32'd0;
            r_rsp_err   <= w_err;
         end
      end
   end

   assign o_mem_addr      = r_req.addr;
   assign o_mem_wd        = r_req.wd;
   assign o_mem_mask_type = r_req.mask;
   assign o_mem_ext_type  = r_req.ext;
   assign o_rsp_id        = r_req.id;
   assign o_rsp_rdata     = r_rsp_rdata;
   assign o_rsp_err       = r_rsp_err;

endmodule
